// File: rtl/vr_traffic_source.sv
// Multi-channel valid/ready traffic generator: one packet per channel per sweep,
// with programmable inter-beat gaps and incrementing or LFSR payloads.
module vr_traffic_source #(
  parameter int DATA_WIDTH = 8,
  parameter int DELAY_BITS = 3,
  parameter int NUM_CH     = 4,
  parameter int LEN_BITS   = 8,
  parameter logic [DATA_WIDTH-1:0] TAP_MASK = DATA_WIDTH'(8'hB8),
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  mode,
  input  logic [DELAY_BITS-1:0] delay,
  input  logic [LEN_BITS-1:0]   pkt_len,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CH_W-1:0]       out_ch,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {S_IDLE, S_GAP, S_SEND} state_t;

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  state_t                state_q, state_d;
  logic                  mode_q, mode_d;
  logic [DELAY_BITS-1:0] delay_q, delay_d;
  logic [DELAY_BITS-1:0] gap_q, gap_d;
  logic [LEN_BITS-1:0]   len_q, len_d;
  logic [LEN_BITS-1:0]   beat_q, beat_d;
  logic [CH_W-1:0]       ch_q, ch_d;
  logic                  done_q, done_d;
  logic                  advance;
  logic                  is_last;
  logic                  sending;

  logic [DATA_WIDTH-1:0] data_q [NUM_CH];
  logic [DATA_WIDTH-1:0] step_w [NUM_CH];
  logic [DATA_WIDTH-1:0] cur_data;

  assign sending = (state_q == S_SEND);
  assign is_last = (beat_q == len_q - LEN_BITS'(1));

  // Next payload per channel; an all-zero LFSR register is forced to 1 so it never sticks.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_step
    assign step_w[gi] = !mode_q              ? data_q[gi] + DATA_WIDTH'(1) :
                        (data_q[gi] == '0)   ? DATA_WIDTH'(1) :
                        {data_q[gi][DATA_WIDTH-2:0], ^(data_q[gi] & TAP_MASK)};
  end

  always_comb begin
    cur_data = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_q == CH_W'(c)) cur_data = data_q[c];
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (reset) begin
        data_q[c] <= DATA_WIDTH'(c + 1);
      end else if (advance && (ch_q == CH_W'(c))) begin
        data_q[c] <= step_w[c];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    delay_d = delay_q;
    gap_d   = gap_q;
    len_d   = len_q;
    beat_d  = beat_q;
    ch_d    = ch_q;
    done_d  = 1'b0;
    advance = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && (pkt_len != '0)) begin
          mode_d  = mode;
          delay_d = delay;
          len_d   = pkt_len;
          ch_d    = '0;
          beat_d  = '0;
          if (delay != '0) begin
            state_d = S_GAP;
            gap_d   = delay - DELAY_BITS'(1);
          end else begin
            state_d = S_SEND;
          end
        end
      end
      S_GAP: begin
        if (gap_q == '0) state_d = S_SEND;
        else             gap_d   = gap_q - DELAY_BITS'(1);
      end
      S_SEND: begin
        if (out_ready) begin
          advance = 1'b1;
          if (!is_last) begin
            beat_d = beat_q + LEN_BITS'(1);
          end else if (ch_q != LAST_CH) begin
            ch_d   = ch_q + CH_W'(1);
            beat_d = '0;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
          // Every beat that continues the sweep is preceded by a fresh gap.
          if (!(is_last && (ch_q == LAST_CH))) begin
            if (delay_q != '0) begin
              state_d = S_GAP;
              gap_d   = delay_q - DELAY_BITS'(1);
            end else begin
              state_d = S_SEND;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      mode_q  <= 1'b0;
      delay_q <= '0;
      gap_q   <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      ch_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      delay_q <= delay_d;
      gap_q   <= gap_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      ch_q    <= ch_d;
      done_q  <= done_d;
    end
  end

  assign out_valid = sending;
  assign out_data  = sending ? cur_data : '0;
  assign out_ch    = sending ? ch_q : '0;
  assign out_last  = sending && is_last;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_vr_traffic_source.sv
// Bench for vr_traffic_source: directed vectors, corner sequences and random sweeps
// checked against a per-channel payload model and gap/handshake timing rules.
module tb_vr_traffic_source;

  logic       clk = 1'b0;
  logic       reset, start, mode, out_ready;
  logic [2:0] delay;
  logic [7:0] pkt_len;
  logic       out_valid, out_last, busy, done;
  logic [7:0] out_data;
  logic [1:0] out_ch;

  always #5 clk = ~clk;

  vr_traffic_source dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .delay(delay),
    .pkt_len(pkt_len), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ch(out_ch), .out_last(out_last),
    .busy(busy), .done(done)
  );

  typedef struct packed {
    logic [1:0] ch;
    logic [7:0] data;
    logic       last;
  } beat_t;

  typedef struct {
    logic m;
    int   d;
    int   len;
    int   first_d;
    int   last_d;
    int   cycles;
  } vec_t;

  localparam int TAPS = 'hB8;

  beat_t got_q[$];
  int    mreg[4];
  int    n_cmp = 0;
  int    n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Payload rule: +1 mod 256, or shift-left with parity of tapped bits; zero escapes to 1.
  function automatic int step(input int v, input logic m);
    int fb;
    fb = 0;
    if (!m) return (v + 1) % 256;
    if (v == 0) return 1;
    for (int b = 0; b < 8; b++) begin
      if ((((TAPS >> b) & 1) == 1) && (((v >> b) & 1) == 1)) fb ^= 1;
    end
    return ((v << 1) & 255) | fb;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; start = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_busy",  32'(busy), 0);
    check("rst_done",  32'(done), 0);
    check("rst_data",  32'(out_data), 0);
    check("rst_ch",    32'(out_ch), 0);
    check("rst_last",  32'(out_last), 0);
    reset = 1'b0;
    for (int c = 0; c < 4; c++) mreg[c] = c + 1;
  endtask

  // Runs one full sweep, checking every beat, gap length, hold stability and done/busy.
  task automatic run_sweep(input logic m, input int d, input int len, input int rdy_pct,
                           input bit poke, output int cyc);
    beat_t exp_q[$];
    beat_t cur, prev;
    int    idle, idx;
    bit    held, hs;
    got_q.delete();
    prev = '0;
    for (int c = 0; c < 4; c++) begin
      for (int b = 0; b < len; b++) begin
        exp_q.push_back('{ch: 2'(c), data: 8'(mreg[c]), last: (b == len - 1)});
        mreg[c] = step(mreg[c], m);
      end
    end
    @(negedge clk);
    start = 1'b1; mode = m; delay = 3'(d); pkt_len = 8'(len);
    @(negedge clk);
    start = 1'b0; mode = 1'($urandom); delay = 3'($urandom); pkt_len = 8'($urandom);
    idle = 0; idx = 0; cyc = 0; held = 0;
    while (idx < exp_q.size() && cyc < 20000) begin
      cyc++;
      check("busy_high", 32'(busy), 1);
      check("done_low", 32'(done), 0);
      cur = '{ch: out_ch, data: out_data, last: out_last};
      if (!out_valid) begin
        check("valid_dropped", 32'(held), 0);
        idle++;
      end else begin
        if (!held) check("gap_len", 32'(idle), 32'(d));
        else       check("hold_stable", 32'(cur), 32'(prev));
        check("beat", 32'(cur), 32'(exp_q[idx]));
        held = 1'b1;
        prev = cur;
      end
      out_ready = ($urandom_range(99) < 32'(rdy_pct));
      start     = poke ? 1'($urandom_range(1)) : 1'b0;
      hs        = out_valid && out_ready;
      @(negedge clk);
      if (hs) begin
        got_q.push_back(prev);
        idx++;
        held = 1'b0;
        idle = 0;
      end
    end
    start = 1'b0;
    check("sweep_beats", 32'(idx), 32'(exp_q.size()));
    check("done_pulse", 32'(done), 1);
    check("busy_fall", 32'(busy), 0);
    check("idle_valid", 32'(out_valid), 0);
    @(negedge clk);
    check("done_once", 32'(done), 0);
    $display("sweep mode=%0d delay=%0d len=%0d ready%%=%0d poke=%0d beats=%0d cycles=%0d",
             m, d, len, rdy_pct, poke, idx, cyc);
  endtask

  initial begin
    vec_t vecs[5];
    int   cyc;
    int   k;

    vecs[0] = '{1'b0, 0, 2, 1, 5, 8};
    vecs[1] = '{1'b0, 3, 1, 1, 4, 16};
    vecs[2] = '{1'b1, 0, 5, 1, 'h47, 20};
    vecs[3] = '{1'b0, 1, 3, 1, 6, 24};
    vecs[4] = '{1'b1, 2, 1, 1, 4, 12};

    reset = 1'b1; start = 1'b0; mode = 1'b0; delay = '0; pkt_len = '0; out_ready = 1'b0;
    do_reset();

    // pkt_len == 0 start is ignored
    @(negedge clk); start = 1'b1; pkt_len = 8'd0;
    @(negedge clk); start = 1'b0;
    check("zero_len_busy", 32'(busy), 0);
    @(negedge clk);
    check("zero_len_valid", 32'(out_valid), 0);

    for (int i = 0; i < 5; i++) begin
      do_reset();
      run_sweep(vecs[i].m, vecs[i].d, vecs[i].len, 100, 1'b0, cyc);
      check("vec_first", 32'(got_q[0].data), 32'(vecs[i].first_d));
      check("vec_last", 32'(got_q[got_q.size()-1].data), 32'(vecs[i].last_d));
      check("vec_cycles", 32'(cyc), 32'(vecs[i].cycles));
    end

    // Back-to-back incrementing sweep, exact beat order
    begin
      int exp_ch[8] = '{0, 0, 1, 1, 2, 2, 3, 3};
      int exp_d[8]  = '{1, 2, 2, 3, 3, 4, 4, 5};
      do_reset();
      run_sweep(1'b0, 0, 2, 100, 1'b0, cyc);
      for (int i = 0; i < 8; i++) begin
        check("t1_ch", 32'(got_q[i].ch), 32'(exp_ch[i]));
        check("t1_data", 32'(got_q[i].data), 32'(exp_d[i]));
        check("t1_last", 32'(got_q[i].last), 32'(i % 2));
      end
    end

    // LFSR from reset on channel 0
    begin
      int exp_l[5] = '{'h01, 'h02, 'h04, 'h08, 'h11};
      do_reset();
      run_sweep(1'b1, 0, 5, 100, 1'b0, cyc);
      for (int i = 0; i < 5; i++) begin
        check("t4_data", 32'(got_q[i].data), 32'(exp_l[i]));
        check("t4_last", 32'(got_q[i].last), 32'(i == 4));
      end
    end

    // Backpressure mid-packet: beat held, accepted exactly once
    do_reset();
    @(negedge clk); start = 1'b1; mode = 1'b0; delay = 3'd0; pkt_len = 8'd2; out_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    check("t3_b0", 32'(out_data), 1);
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("t3_valid", 32'(out_valid), 1);
      check("t3_data", 32'(out_data), 2);
      check("t3_ch", 32'(out_ch), 0);
      check("t3_last", 32'(out_last), 1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("t3_next_ch", 32'(out_ch), 1);
    check("t3_next_data", 32'(out_data), 2);
    @(negedge clk);
    check("t3_once_ch", 32'(out_ch), 1);
    check("t3_once_last", 32'(out_last), 0);
    out_ready = 1'b1;
    k = 0;
    while (busy && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("t3_finished", 32'(busy), 0);

    // Payload wrap, then LFSR escape from zero
    do_reset();
    run_sweep(1'b0, 0, 254, 100, 1'b0, cyc);
    run_sweep(1'b0, 0, 1, 100, 1'b0, cyc);
    check("t5_ff", 32'(got_q[0].data), 'hFF);
    run_sweep(1'b1, 0, 2, 100, 1'b0, cyc);
    check("t5_zero", 32'(got_q[0].data), 'h00);
    check("t5_one", 32'(got_q[1].data), 'h01);

    // Reset mid-packet abandons the sweep and reseeds
    do_reset();
    @(negedge clk); start = 1'b1; mode = 1'b0; delay = 3'd1; pkt_len = 8'd4; out_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    check("t6_busy_before", 32'(busy), 1);
    reset = 1'b1;
    @(negedge clk);
    check("t6_valid", 32'(out_valid), 0);
    check("t6_busy", 32'(busy), 0);
    reset = 1'b0;
    for (int c = 0; c < 4; c++) mreg[c] = c + 1;
    run_sweep(1'b0, 0, 1, 100, 1'b0, cyc);
    check("t6_seed0", 32'(got_q[0].data), 1);
    check("t6_seed3", 32'(got_q[3].data), 4);

    // Random sweeps with backpressure and stray start pulses
    for (int i = 0; i < 10; i++) begin
      run_sweep(1'($urandom), int'($urandom_range(7)), int'($urandom_range(6, 1)),
                int'($urandom_range(100, 30)), 1'($urandom), cyc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
